// File: rtl/hyper_rx_packer_pkg.sv
// -----------------------------------------------------------------------------
// hyper_rx_packer_pkg
// Shared types and helpers for the HyperBus RX byte packer.
//   hyper_dsize_e    : beat size code on the controller's data_rx stream
//   hyper_rx_word_t  : packed 32-bit word plus contiguous byte enables
//   hyper_rx_state_e : packer FSM states (ACC = packing, FLUSH = draining tail)
// -----------------------------------------------------------------------------
package hyper_rx_packer_pkg;

    typedef enum logic [1:0] {
        DS_BYTE  = 2'b00,
        DS_HALF  = 2'b01,
        DS_WORD  = 2'b10,
        DS_WORD2 = 2'b11
    } hyper_dsize_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } hyper_rx_word_t;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_FLUSH = 1'b1
    } hyper_rx_state_e;

    // Number of valid bytes carried by a beat (1, 2 or 4).
    function automatic logic [2:0] dsize_bytes(input hyper_dsize_e ds);
        case (ds)
            DS_BYTE: return 3'd1;
            DS_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte enables for the lowest n bytes of a beat.
    function automatic logic [3:0] nbytes_to_be(input logic [2:0] n);
        case (n)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // (1 << cnt) - 1 : enables for a partial word holding cnt bytes.
    function automatic logic [3:0] cnt_to_be(input logic [1:0] cnt);
        case (cnt)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    // Expand a 4-bit byte enable into a 32-bit lane mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/hyper_rx_packer_if.sv
// -----------------------------------------------------------------------------
// hyper_rx_packer_if
// Bundles the two streams around the packer.
//   in_*  : beat stream from the hyper controller (data right-aligned, size code)
//   out_* : packed-word stream towards the uDMA RX channel
// Handshake: on both streams a transfer happens on a rising clock edge where
// valid and ready are both high; valid must not depend on ready.
// Modports:
//   master : the surroundings (drives beats, accepts words)
//   slave  : the packer itself
// -----------------------------------------------------------------------------
interface hyper_rx_packer_if;
    import hyper_rx_packer_pkg::*;

    logic [31:0]  in_data_i;
    hyper_dsize_e in_datasize_i;
    logic         in_valid_i;
    logic         in_ready_o;

    logic [31:0]  out_data_o;
    logic [3:0]   out_be_o;
    logic         out_valid_o;
    logic         out_ready_i;

    modport master (
        output in_data_i, in_datasize_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_be_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_datasize_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_be_o, out_valid_o
    );

endinterface

// File: rtl/hyper_rx_packer_fifo.sv
// -----------------------------------------------------------------------------
// hyper_rx_fifo
// Registered synchronous FIFO (not fall-through): an entry written on edge t is
// visible at data_o from t+1. Push while full is legal only with a same-cycle pop.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : synchronous clear, empties the FIFO
//   push_i     : write data_i
//   pop_i      : drop the head entry
//   data_o     : head entry (undefined content while empty)
//   full_o     : level == DEPTH
//   empty_o    : level == 0
//   level_o    : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module hyper_rx_fifo
    import hyper_rx_packer_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = hyper_rx_word_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level == LW'(DEPTH));
    assign empty_o = (level == '0);
    assign level_o = level;
    assign data_o  = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted in level.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(pop_i && empty_o));

endmodule

// File: rtl/hyper_rx_packer.sv
// -----------------------------------------------------------------------------
// hyper_rx_packer
// Packs 1/2/4-byte RX beats little-endian into 32-bit words with byte enables
// and queues them in a small FIFO. A flush request drains any partial word and
// raises a single-cycle eot_o.
// Ports:
//   sys_clk_i  : clock
//   rst_i      : asynchronous active-high reset
//   clr_i      : synchronous clear of accumulator, FIFO and pending flush
//   flush_i    : 1-cycle end-of-transfer request
//   bus        : beat input stream and packed-word output stream
//   eot_o      : 1-cycle pulse when the flush has completed
//   level_o    : FIFO occupancy
//   state_o    : current FSM state (debug)
// -----------------------------------------------------------------------------
module hyper_rx_packer
    import hyper_rx_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        flush_i,
    hyper_rx_packer_if.slave            bus,
    output logic                        eot_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output hyper_rx_state_e             state_o
);

    hyper_rx_state_e state_q, state_d;
    logic [31:0]     acc_q, acc_d;   // lanes >= cnt_q are kept at zero
    logic [1:0]      cnt_q, cnt_d;
    logic            run_q;          // holds in_ready_o low for the first cycle after reset

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            accept;
    hyper_rx_word_t  push_word;
    hyper_rx_word_t  head_word;

    logic [2:0]      nbytes;
    logic [31:0]     beat_m;
    logic [63:0]     merged;
    logic [2:0]      total;

    assign state_o = state_q;

    assign bus.in_ready_o  = run_q & (state_q == ST_ACC) & ~fifo_full;
    assign bus.out_valid_o = ~fifo_empty;
    assign bus.out_data_o  = fifo_empty ? 32'h0 : head_word.data;
    assign bus.out_be_o    = fifo_empty ? 4'h0  : head_word.be;

    // clr_i drops the presented beat and makes a same-cycle pop meaningless.
    assign accept = bus.in_valid_i & bus.in_ready_o & ~clr_i;
    assign pop    = bus.out_valid_o & bus.out_ready_i & ~clr_i;

    // Packing datapath: place the masked beat at lane cnt_q of a 64-bit window;
    // the low half is the word being built, the high half carries overflow.
    assign nbytes = dsize_bytes(bus.in_datasize_i);
    assign beat_m = bus.in_data_i & be_to_mask(nbytes_to_be(nbytes));
    assign merged = {32'h0, acc_q} | ({32'h0, beat_m} << {cnt_q, 3'b000});
    assign total  = {1'b0, cnt_q} + nbytes;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = '0;
        eot_o     = 1'b0;

        case (state_q)
            ST_ACC: begin
                // A beat accepted together with flush_i is packed before the flush.
                if (accept) begin
                    cnt_d = total[1:0];
                    if (total[2]) begin
                        push      = 1'b1;
                        push_word = '{data: merged[31:0], be: 4'hF};
                        acc_d     = merged[63:32];
                    end else begin
                        acc_d     = merged[31:0];
                    end
                end
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 2'd0) begin
                    eot_o   = 1'b1;
                    state_d = ST_ACC;
                end else if (!fifo_full || pop) begin
                    push      = 1'b1;
                    push_word = '{data: acc_q & be_to_mask(cnt_to_be(cnt_q)),
                                  be:   cnt_to_be(cnt_q)};
                    acc_d     = '0;
                    cnt_d     = 2'd0;
                    eot_o     = 1'b1;
                    state_d   = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        if (clr_i) begin
            push      = 1'b0;
            push_word = '0;
            eot_o     = 1'b0;
            acc_d     = '0;
            cnt_d     = 2'd0;
            state_d   = ST_ACC;
        end
    end

    hyper_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (hyper_rx_word_t)
    ) u_fifo (
        .clk     (sys_clk_i),
        .rst     (rst_i),
        .clr_i   (clr_i),
        .push_i  (push),
        .data_i  (push_word),
        .pop_i   (pop),
        .data_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    a_be_legal : assert property (@(posedge sys_clk_i) disable iff (rst_i)
        bus.out_valid_o |-> (bus.out_be_o inside {4'b0001, 4'b0011, 4'b0111, 4'b1111}));
    a_eot_single : assert property (@(posedge sys_clk_i) disable iff (rst_i)
        eot_o |=> !eot_o);

endmodule

// File: tb/tb_hyper_rx_packer.sv
// -----------------------------------------------------------------------------
// tb_hyper_rx_packer
// Directed scenarios plus random traffic against a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_hyper_rx_packer;
    import hyper_rx_packer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            sys_clk_i = 1'b0;
    logic            rst_i;
    logic            clr_i;
    logic            flush_i;
    logic            eot_o;
    logic [LW-1:0]   level_o;
    hyper_rx_state_e state_o;

    hyper_rx_packer_if bus ();

    hyper_rx_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .flush_i   (flush_i),
        .bus       (bus),
        .eot_o     (eot_o),
        .level_o   (level_o),
        .state_o   (state_o)
    );

    // ---------------- clock ----------------
    always #5 sys_clk_i = ~sys_clk_i;

    // ---------------- reference model ----------------
    logic [7:0]  pend_q[$];   // bytes received but not yet in a queued word
    logic [35:0] exp_q[$];    // expected FIFO contents {be, data}, head first
    bit          m_flush;     // flush requested, not yet completed
    bit          m_live;      // at least one clock edge since reset release

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        m_flush = 1'b0;
        m_live  = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, compare, advance model at the rising edge.
    task automatic step(input logic v, input logic [1:0] ds, input logic [31:0] d,
                        input logic fl, input logic ordy, input logic cl);
        bit          full, pop, e_ready, e_eot;
        logic [35:0] e_word;
        logic [31:0] w;
        int          n;
        bus.in_valid_i    = v;
        bus.in_datasize_i = hyper_dsize_e'(ds);
        bus.in_data_i     = d;
        bus.out_ready_i   = ordy;
        flush_i           = fl;
        clr_i             = cl;
        #1;
        full    = (exp_q.size() == DEPTH);
        pop     = ordy && (exp_q.size() > 0);
        e_ready = m_live && !m_flush && !full;
        e_eot   = !cl && m_flush && (pend_q.size() == 0 || !full || pop);
        e_word  = (exp_q.size() > 0) ? exp_q[0] : 36'h0;
        check("in_ready",  36'(bus.in_ready_o),  36'(e_ready));
        check("out_valid", 36'(bus.out_valid_o), 36'(exp_q.size() > 0));
        check("out_word",  {bus.out_be_o, bus.out_data_o}, e_word);
        check("level",     36'(level_o),         36'(exp_q.size()));
        check("eot",       36'(eot_o),           36'(e_eot));
        @(posedge sys_clk_i);
        if (cl) begin
            pend_q.delete();
            exp_q.delete();
            m_flush = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (v && e_ready) begin
                n = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
                for (int i = 0; i < n; i++) pend_q.push_back(d[8*i +: 8]);
                if (pend_q.size() >= 4) begin
                    w = '0;
                    for (int i = 0; i < 4; i++) w[8*i +: 8] = pend_q.pop_front();
                    exp_q.push_back({4'hF, w});
                end
            end
            if (!m_flush) begin
                if (fl) m_flush = 1'b1;
            end else if (e_eot) begin
                if (pend_q.size() > 0) begin
                    w = '0;
                    n = pend_q.size();
                    for (int i = 0; i < n; i++) w[8*i +: 8] = pend_q[i];
                    exp_q.push_back({4'((1 << n) - 1), w});
                    pend_q.delete();
                end
                m_flush = 1'b0;
            end
        end
        m_live = 1'b1;
        @(negedge sys_clk_i);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'd0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1;
        clr_i = 1'b0;
        flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_datasize_i = DS_BYTE;
        bus.in_data_i = '0;
        bus.out_ready_i = 1'b0;
        model_reset();

        // Reset values
        #12;
        check("rst_in_ready",  36'(bus.in_ready_o),  36'h0);
        check("rst_out_valid", 36'(bus.out_valid_o), 36'h0);
        check("rst_level",     36'(level_o),         36'h0);
        check("rst_eot",       36'(eot_o),           36'h0);
        @(negedge sys_clk_i);
        rst_i = 1'b0;
        idle(1'b0);

        // Four byte beats -> 0x44332211
        step(1, 2'd0, 32'h11, 0, 1, 0);
        step(1, 2'd0, 32'h22, 0, 1, 0);
        step(1, 2'd0, 32'h33, 0, 1, 0);
        step(1, 2'd0, 32'h44, 0, 1, 0);
        check("t1_word", {bus.out_be_o, bus.out_data_o}, 36'hF_44332211);
        idle(1'b1);

        // Half/byte/half then flush
        step(1, 2'd1, 32'hFFFF_BBAA, 0, 0, 0);
        step(1, 2'd0, 32'hFFFF_FFCC, 0, 0, 0);
        step(1, 2'd1, 32'h1234_EEDD, 0, 0, 0);
        step(0, 2'd0, 32'h0, 1, 0, 0);
        check("t2_eot", 36'(eot_o), 36'h1);
        idle(1'b0);
        check("t2_level", 36'(level_o), 36'h2);
        check("t2_head0", {bus.out_be_o, bus.out_data_o}, 36'hF_DDCCBBAA);
        idle(1'b1);
        check("t2_head1", {bus.out_be_o, bus.out_data_o}, 36'h1_000000EE);
        idle(1'b1);

        // Fill the FIFO with back-pressure, then drain
        for (int i = 0; i < 4; i++) step(1, 2'd2, $urandom, 0, 0, 0);
        check("t3_level", 36'(level_o), 36'h4);
        check("t3_ready", 36'(bus.in_ready_o), 36'h0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with nothing pending
        step(0, 2'd0, 32'h0, 1, 1, 0);
        check("t4_eot", 36'(eot_o), 36'h1);
        idle(1'b1);
        check("t4_eot_off", 36'(eot_o), 36'h0);

        // Flush with FIFO full and two bytes pending
        step(1, 2'd1, 32'h0000_5A5A, 0, 0, 0);
        step(1, 2'd2, 32'h0102_0304, 0, 0, 0);
        step(1, 2'd3, 32'h0506_0708, 0, 0, 0);
        step(1, 2'd2, 32'h090A_0B0C, 0, 0, 0);
        step(1, 2'd2, 32'hCAFE_BABE, 0, 0, 0);
        check("t5_full", 36'(level_o), 36'h4);
        step(0, 2'd0, 32'h0, 1, 0, 0);
        idle(1'b0);
        idle(1'b0);
        check("t5_eot_wait", 36'(eot_o), 36'h0);
        idle(1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t5_tail", {bus.out_be_o, bus.out_data_o}, 36'h3_0000CAFE);
        idle(1'b1);

        // Clear with 2 words queued and 3 bytes pending
        for (int i = 0; i < 11; i++) step(1, 2'd0, 32'(8'hA0 + i), 0, 0, 0);
        check("t6_pre", 36'(level_o), 36'h2);
        step(1, 2'd0, 32'hEE, 0, 1, 1);
        check("t6_level", 36'(level_o), 36'h0);
        check("t6_valid", 36'(bus.out_valid_o), 36'h0);
        for (int i = 1; i <= 4; i++) step(1, 2'd0, 32'(i), 0, 0, 0);
        check("t6_word", {bus.out_be_o, bus.out_data_o}, 36'hF_04030201);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 59) == 0);
        end

        // Asynchronous reset in the middle of a beat stream
        for (int c = 0; c < 10; c++) step(1, 2'($urandom_range(0, 3)), $urandom, 0, 0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_ready", 36'(bus.in_ready_o), 36'h0);
        check("arst_word",  {bus.out_be_o, bus.out_data_o}, 36'h0);
        check("arst_valid", 36'(bus.out_valid_o), 36'h0);
        check("arst_level", 36'(level_o), 36'h0);
        check("arst_eot",   36'(eot_o), 36'h0);
        bus.in_valid_i = 1'b0;
        model_reset();
        @(negedge sys_clk_i);
        @(negedge sys_clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) != 0, 1'b0);
        end
        step(0, 2'd0, 32'h0, 1, 1, 0);
        for (int c = 0; c < 8; c++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
